// File: rtl/fall_move_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : fall_move_ctl
//  Purpose  : Frame-synchronous falling-sprite motion controller. Steps the
//             sprite y position once per frame at the rising edge of vblank,
//             applying integer gravity with a velocity ceiling, and stops at
//             a floor row. Outputs change only on vblank entry, so a drawn
//             frame never sees a half-updated position.
//  Revision : 1.0  initial release
// ============================================================================
module fall_move_ctl #(
    parameter int Y_INIT  = 0,      // start row, must be below Y_FLOOR
    parameter int Y_FLOOR = 536,    // landing row
    parameter int V_MAX   = 16,     // velocity ceiling in px/frame (1..255)
    parameter int G_DIV   = 4       // frames per +1 velocity step (1..255)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic [10:0] x_in,
    output logic [10:0] xpos_out,
    output logic [10:0] ypos_out,
    output logic        busy,
    output logic        done
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_FALL   = 2'd2;
    localparam logic [1:0] S_LANDED = 2'd3;

    // Parameters resized once to the datapath widths they are compared with.
    localparam logic [10:0] C_Y_INIT    = 11'(Y_INIT);
    localparam logic [11:0] C_Y_FLOOR12 = 12'(Y_FLOOR);
    localparam logic [10:0] C_Y_FLOOR11 = 11'(Y_FLOOR);
    localparam logic [7:0]  C_V_MAX     = 8'(V_MAX);
    localparam logic [7:0]  C_FCNT_LAST = 8'(G_DIV - 1);

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic [10:0] xpos_q,  xpos_d;
    logic [10:0] ypos_q,  ypos_d;
    logic [7:0]  vel_q,   vel_d;
    logic [7:0]  fcnt_q,  fcnt_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic        vblnk_q;

    logic        tick;
    logic [11:0] y_sum;
    logic [7:0]  vel_inc;

    // Frame tick: one cycle at the first clock of vblank. The delay register
    // resets high so a vblank already active at reset release is not a tick.
    assign tick = vblnk_in & ~vblnk_q;

    // One extra bit so a step near the top of the 11-bit range cannot wrap
    // around and slip under the floor comparison.
    assign y_sum = {1'b0, ypos_q} + {4'b0000, vel_q};

    // Saturating velocity increment; the >= also protects vel_q == 255.
    assign vel_inc = (vel_q >= C_V_MAX) ? C_V_MAX : (vel_q + 8'd1);

    // Vblank edge detector delay register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_q <= 1'b1;
        end else begin
            vblnk_q <= vblnk_in;
        end
    end

    // Next-state logic: drop control, per-frame step, floor clamp, gravity.
    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        vel_d   = vel_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;

        case (state_q)
            // A tick coinciding with start is deliberately not consumed here:
            // the drop always waits for a full frame boundary in ARMED.
            S_IDLE, S_LANDED: begin
                if (start) begin
                    xpos_d  = x_in;
                    ypos_d  = C_Y_INIT;
                    vel_d   = 8'd1;
                    fcnt_d  = 8'd0;
                    state_d = S_ARMED;
                end
            end

            // First frame boundary only synchronises; no movement yet.
            S_ARMED: begin
                if (tick) begin
                    state_d = S_FALL;
                end
            end

            S_FALL: begin
                if (tick) begin
                    if (y_sum >= C_Y_FLOOR12) begin
                        ypos_d  = C_Y_FLOOR11;
                        state_d = S_LANDED;
                        done_d  = 1'b1;
                    end else begin
                        ypos_d = y_sum[10:0];
                        if (fcnt_q == C_FCNT_LAST) begin
                            fcnt_d = 8'd0;
                            vel_d  = vel_inc;
                        end else begin
                            fcnt_d = fcnt_q + 8'd1;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ARMED) || (state_d == S_FALL);
    end

    // State and output registers; reset clears everything including done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            xpos_q  <= 11'd0;
            ypos_q  <= C_Y_INIT;
            vel_q   <= 8'd0;
            fcnt_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            vel_q   <= vel_d;
            fcnt_q  <= fcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign xpos_out = xpos_q;
    assign ypos_out = ypos_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fall_move_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fall_move_ctl
//  Purpose  : Self-checking bench for fall_move_ctl. Three instances share
//             stimulus: default parameters, a low floor (Y_FLOOR=10) and a
//             fast-saturating variant (V_MAX=2, G_DIV=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fall_move_ctl;

    logic        clk;
    logic        rst;
    logic        vblnk_in;
    logic        start;
    logic [10:0] x_in;

    logic [10:0] xpos_def, ypos_def, xpos_f10, ypos_f10, xpos_v2, ypos_v2;
    logic        busy_def, done_def, busy_f10, done_f10, busy_v2, done_v2;

    int n_tests;
    int n_fail;

    // done captured on the tick result cycle (d1) and the cycle after (d2)
    int d1_def, d1_f10, d1_v2, d2_def, d2_f10, d2_v2;

    fall_move_ctl u_def (
        .clk(clk), .rst(rst), .vblnk_in(vblnk_in), .start(start), .x_in(x_in),
        .xpos_out(xpos_def), .ypos_out(ypos_def), .busy(busy_def), .done(done_def)
    );

    fall_move_ctl #(.Y_FLOOR(10)) u_f10 (
        .clk(clk), .rst(rst), .vblnk_in(vblnk_in), .start(start), .x_in(x_in),
        .xpos_out(xpos_f10), .ypos_out(ypos_f10), .busy(busy_f10), .done(done_f10)
    );

    fall_move_ctl #(.V_MAX(2), .G_DIV(1)) u_v2 (
        .clk(clk), .rst(rst), .vblnk_in(vblnk_in), .start(start), .x_in(x_in),
        .xpos_out(xpos_v2), .ypos_out(ypos_v2), .busy(busy_v2), .done(done_v2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int y_def;
        int y_f10;
        int y_v2;
        int done_f10;
        int busy_f10;
    } vec_t;

    // Reference: y after n falling frames. Velocity in frame k (0-based) is
    // 1 + k/gdiv capped at vmax; position clamps to the floor once reached.
    function automatic int model_y(input int n, input int yinit, input int floor_y,
                                   input int vmax, input int gdiv);
        int y;
        int v;
        y = yinit;
        for (int k = 0; k < n; k++) begin
            v = 1 + k / gdiv;
            if (v > vmax) v = vmax;
            y = y + v;
            if (y >= floor_y) return floor_y;
        end
        return y;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int x);
        @(negedge clk);
        start = 1'b1;
        x_in  = 11'(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    // One frame: raise vblank, sample results after the tick edge and one
    // cycle later, hold vblank, then return to active video.
    task automatic frame(input int hold, input int gap);
        @(negedge clk);
        vblnk_in = 1'b1;
        @(negedge clk);
        d1_def = int'(done_def); d1_f10 = int'(done_f10); d1_v2 = int'(done_v2);
        @(negedge clk);
        d2_def = int'(done_def); d2_f10 = int'(done_f10); d2_v2 = int'(done_v2);
        cyc(hold);
        vblnk_in = 1'b0;
        cyc(gap);
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk({tag, " rst ypos_def"}, int'(ypos_def), 0);
        chk({tag, " rst busy_def"}, int'(busy_def), 0);
        chk({tag, " rst done_f10"}, int'(done_f10), 0);
        chk({tag, " rst xpos_v2"},  int'(xpos_v2),  0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        int x_r;
        int nt;
        int ym;
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{1,  1,  1,  0, 1};
        vecs[1]  = '{2,  2,  3,  0, 1};
        vecs[2]  = '{3,  3,  5,  0, 1};
        vecs[3]  = '{4,  4,  7,  0, 1};
        vecs[4]  = '{6,  6,  9,  0, 1};
        vecs[5]  = '{8,  8,  11, 0, 1};
        vecs[6]  = '{10, 10, 13, 1, 0};
        vecs[7]  = '{12, 10, 15, 0, 0};
        vecs[8]  = '{15, 10, 17, 0, 0};
        vecs[9]  = '{18, 10, 19, 0, 0};
        vecs[10] = '{21, 10, 21, 0, 0};
        vecs[11] = '{24, 10, 23, 0, 0};

        // Reset with vblank high; release while vblank stays high.
        rst = 1'b1; vblnk_in = 1'b1; start = 1'b0; x_in = '0;
        cyc(3);
        rst = 1'b0;
        cyc(5);
        chk("reset ypos",  int'(ypos_def), 0);
        chk("reset xpos",  int'(xpos_def), 0);
        chk("reset busy",  int'(busy_def), 0);
        chk("reset done",  int'(done_def), 0);

        // Default drop from x=400, plus floor and saturation variants.
        vblnk_in = 1'b0;
        cyc(3);
        pulse_start(400);
        chk("armed busy", int'(busy_def), 1);
        chk("armed xpos", int'(xpos_def), 400);
        frame(2, 3);
        chk("arming tick ypos", int'(ypos_def), 0);
        chk("arming tick busy", int'(busy_def), 1);

        for (int i = 0; i < 12; i++) begin
            if (i == 4) pulse_start(123);   // ignored while falling
            frame(2, 3);
            chk($sformatf("vec%0d ypos_def", i), int'(ypos_def), vecs[i].y_def);
            chk($sformatf("vec%0d ypos_f10", i), int'(ypos_f10), vecs[i].y_f10);
            chk($sformatf("vec%0d ypos_v2", i),  int'(ypos_v2),  vecs[i].y_v2);
            chk($sformatf("vec%0d done_f10", i), d1_f10, vecs[i].done_f10);
            chk($sformatf("vec%0d done_f10 next", i), d2_f10, 0);
            chk($sformatf("vec%0d busy_f10", i), int'(busy_f10), vecs[i].busy_f10);
            chk($sformatf("vec%0d busy_def", i), int'(busy_def), 1);
            chk($sformatf("vec%0d xpos_def", i), int'(xpos_def), 400);
        end

        // Re-drop from LANDED; falling instances ignore the same pulse.
        pulse_start(77);
        chk("redrop xpos_f10", int'(xpos_f10), 77);
        chk("redrop ypos_f10", int'(ypos_f10), 0);
        chk("redrop busy_f10", int'(busy_f10), 1);
        chk("redrop xpos_def", int'(xpos_def), 400);
        chk("redrop ypos_def", int'(ypos_def), 24);

        // Reset, then start in the same cycle as a tick.
        async_reset_check("mid");
        vblnk_in = 1'b0;
        cyc(3);
        @(negedge clk);
        vblnk_in = 1'b1; start = 1'b1; x_in = 11'd555;
        @(negedge clk);
        start = 1'b0;
        chk("coinc busy", int'(busy_def), 1);
        chk("coinc ypos", int'(ypos_def), 0);
        chk("coinc xpos", int'(xpos_def), 555);
        cyc(2);
        vblnk_in = 1'b0;
        cyc(3);
        frame(2, 3);
        chk("coinc 1st tick ypos", int'(ypos_def), 0);
        for (int k = 1; k <= 5; k++) begin
            frame(1, 2);
            chk($sformatf("coinc tick%0d ypos", k), int'(ypos_def), model_y(k, 0, 536, 16, 4));
        end

        // Reset after the 5th tick, then restart from the top.
        async_reset_check("after5");
        cyc(2);
        chk("after5 no done", int'(done_def), 0);
        pulse_start(9);
        frame(1, 2);
        frame(1, 2);
        chk("restart ypos", int'(ypos_def), 1);

        // Randomized drops against the reference model.
        for (int r = 0; r < 6; r++) begin
            async_reset_check($sformatf("rnd%0d", r));
            x_r = int'($urandom_range(0, 2047));
            pulse_start(x_r);
            frame(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
            chk("rnd arm ypos", int'(ypos_v2), 0);
            nt = int'($urandom_range(3, 30));
            for (int k = 1; k <= nt; k++) begin
                if (model_y(k - 1, 0, 10, 16, 4) < 10 && $urandom_range(0, 3) == 0)
                    pulse_start(int'($urandom_range(0, 2047)));
                frame(int'($urandom_range(0, 3)), int'($urandom_range(1, 5)));
                ym = model_y(k, 0, 536, 16, 4);
                chk($sformatf("rnd%0d k%0d ypos_def", r, k), int'(ypos_def), ym);
                chk($sformatf("rnd%0d k%0d busy_def", r, k), int'(busy_def), int'(ym < 536));
                ym = model_y(k, 0, 10, 16, 4);
                chk($sformatf("rnd%0d k%0d ypos_f10", r, k), int'(ypos_f10), ym);
                chk($sformatf("rnd%0d k%0d busy_f10", r, k), int'(busy_f10), int'(ym < 10));
                chk($sformatf("rnd%0d k%0d done_f10", r, k), d1_f10,
                    int'(ym == 10 && model_y(k - 1, 0, 10, 16, 4) < 10));
                chk($sformatf("rnd%0d k%0d done_f10 next", r, k), d2_f10, 0);
                chk($sformatf("rnd%0d k%0d ypos_v2", r, k), int'(ypos_v2),
                    model_y(k, 0, 536, 2, 1));
                chk($sformatf("rnd%0d k%0d done_def", r, k), d1_def + d1_v2, 0);
                chk($sformatf("rnd%0d k%0d xpos_v2", r, k), int'(xpos_v2), x_r);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
